// File: rtl/pia8255_io_if.sv
// rtl/pia8255_io_if.sv - registered CPU bus between the address decoder and the PIA
interface pia8255_io_if;
   logic       enable;
   logic       rnw;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output enable, output rnw, output addr, output din, input dout);
   modport slave  (input enable, input rnw, input addr, input din, output dout);
endinterface

// File: rtl/pia8255_io.sv
// rtl/pia8255_io.sv - 8255-compatible PIA: mode 0 ports, BSR, mode 1 strobed handshakes with irq
module pia8255_io #(
   parameter logic [7:0] CTRL_RESET  = 8'h9B,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] UNUSED_RD   = 8'h00
) (
   input  logic         clk,
   input  logic         reset_n,
   pia8255_io_if.slave  bus,
   input  logic [7:0]   pa_in,
   input  logic [7:0]   pb_in,
   input  logic [7:0]   pc_in,
   output logic [7:0]   pa_out,
   output logic [7:0]   pb_out,
   output logic [7:0]   pc_out,
   output logic [7:0]   pa_oe,
   output logic [7:0]   pb_oe,
   output logic [7:0]   pc_oe,
   output logic         irq
);

   localparam int NS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

   logic [7:0] ctrl;
   logic [7:0] pa_lat, pb_lat, pc_lat, ina_lat, inb_lat;
   logic       ibf_a, obf_a_n, intr_a, inte_a;
   logic       ibf_b, obf_b_n, intr_b, inte_b;
   logic [7:0] pa_sync [NS];
   logic [7:0] pb_sync [NS];
   logic [7:0] pc_sync [NS];
   logic [7:0] pa_s, pb_s, pc_s, pc_prev;
   logic [7:0] stat_mask, stat_val, stb_mask;

   logic a_m1, a_in, b_m1, b_in, a_in_m1, a_out_m1;
   logic wr, rd, wr_ctrl, wr_bsr, wr_a, wr_b, rd_a, rd_b;
   logic [2:0] bsr_bit;
   logic bsr_inte_a, bsr_inte_b, bsr_lat;
   logic stb_a_fall, stb_a_rise, ack_a_fall, ack_a_rise, hs_b_fall, hs_b_rise;

   assign a_m1     = (ctrl[6:5] == 2'b01);
   assign a_in     = ctrl[4];
   assign b_m1     = ctrl[2];
   assign b_in     = ctrl[1];
   assign a_in_m1  = a_m1 & a_in;
   assign a_out_m1 = a_m1 & ~a_in;

   assign pa_s = pa_sync[NS-1];
   assign pb_s = pb_sync[NS-1];
   assign pc_s = pc_sync[NS-1];

   assign wr      = bus.enable & ~bus.rnw;
   assign rd      = bus.enable & bus.rnw;
   assign wr_ctrl = wr & (bus.addr == 2'd3) & bus.din[7];
   assign wr_bsr  = wr & (bus.addr == 2'd3) & ~bus.din[7];
   assign wr_a    = wr & (bus.addr == 2'd0);
   assign wr_b    = wr & (bus.addr == 2'd1);
   assign rd_a    = rd & (bus.addr == 2'd0);
   assign rd_b    = rd & (bus.addr == 2'd1);

   // BSR on a handshake strobe bit programs INTE; BSR on a status output is dropped
   assign bsr_bit    = bus.din[3:1];
   assign bsr_inte_a = (a_in_m1 && bsr_bit == 3'd4) || (a_out_m1 && bsr_bit == 3'd6);
   assign bsr_inte_b = b_m1 && bsr_bit == 3'd2;
   assign bsr_lat    = wr_bsr & ~stat_mask[bsr_bit] & ~bsr_inte_a & ~bsr_inte_b;

   assign stb_a_fall = a_in_m1  &  pc_prev[4] & ~pc_s[4];
   assign stb_a_rise = a_in_m1  & ~pc_prev[4] &  pc_s[4];
   assign ack_a_fall = a_out_m1 &  pc_prev[6] & ~pc_s[6];
   assign ack_a_rise = a_out_m1 & ~pc_prev[6] &  pc_s[6];
   assign hs_b_fall  = b_m1     &  pc_prev[2] & ~pc_s[2];
   assign hs_b_rise  = b_m1     & ~pc_prev[2] &  pc_s[2];

   always_comb begin
      stat_mask = 8'h00;
      stat_val  = 8'h00;
      stb_mask  = 8'h00;
      if (a_in_m1) begin
         stat_mask[5] = 1'b1;
         stat_mask[3] = 1'b1;
         stb_mask[4]  = 1'b1;
         stat_val[5]  = ibf_a;
         stat_val[3]  = intr_a;
      end
      if (a_out_m1) begin
         stat_mask[7] = 1'b1;
         stat_mask[3] = 1'b1;
         stb_mask[6]  = 1'b1;
         stat_val[7]  = obf_a_n;
         stat_val[3]  = intr_a;
      end
      if (b_m1) begin
         stat_mask[1] = 1'b1;
         stat_mask[0] = 1'b1;
         stb_mask[2]  = 1'b1;
         stat_val[1]  = b_in ? ibf_b : obf_b_n;
         stat_val[0]  = intr_b;
      end
   end

   assign pa_oe  = {8{~a_in}};
   assign pb_oe  = {8{~b_in}};
   assign pc_oe  = ({{4{~ctrl[3]}}, {4{~ctrl[0]}}} | stat_mask) & ~stb_mask;
   assign pa_out = pa_lat;
   assign pb_out = pb_lat;
   assign pc_out = (pc_lat & ~stat_mask) | (stat_val & stat_mask);
   assign irq    = intr_a | intr_b;

   always_comb begin
      bus.dout = UNUSED_RD;
      case (bus.addr)
         2'd0:    bus.dout = a_in ? (a_m1 ? ina_lat : pa_s) : pa_lat;
         2'd1:    bus.dout = b_in ? (b_m1 ? inb_lat : pb_s) : pb_lat;
         2'd2:    bus.dout = (pc_out & pc_oe) | (pc_s & ~pc_oe);
         default: bus.dout = UNUSED_RD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NS; i++) begin
            pa_sync[i] <= 8'h00;
            pb_sync[i] <= 8'h00;
            pc_sync[i] <= 8'h00;
         end
         pc_prev <= 8'h00;
      end else begin
         pa_sync[0] <= pa_in;
         pb_sync[0] <= pb_in;
         pc_sync[0] <= pc_in;
         for (int i = 1; i < NS; i++) begin
            pa_sync[i] <= pa_sync[i-1];
            pb_sync[i] <= pb_sync[i-1];
            pc_sync[i] <= pc_sync[i-1];
         end
         pc_prev <= pc_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl    <= CTRL_RESET;
         pa_lat  <= 8'h00;
         pb_lat  <= 8'h00;
         pc_lat  <= 8'h00;
         ina_lat <= 8'h00;
         inb_lat <= 8'h00;
         ibf_a   <= 1'b0;
         obf_a_n <= 1'b1;
         intr_a  <= 1'b0;
         inte_a  <= 1'b0;
         ibf_b   <= 1'b0;
         obf_b_n <= 1'b1;
         intr_b  <= 1'b0;
         inte_b  <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl    <= bus.din;
         pa_lat  <= 8'h00;
         pb_lat  <= 8'h00;
         pc_lat  <= 8'h00;
         ibf_a   <= 1'b0;
         obf_a_n <= 1'b1;
         intr_a  <= 1'b0;
         inte_a  <= 1'b0;
         ibf_b   <= 1'b0;
         obf_b_n <= 1'b1;
         intr_b  <= 1'b0;
         inte_b  <= 1'b0;
      end else begin
         if (wr_a) pa_lat <= bus.din;
         if (wr_b) pb_lat <= bus.din;
         if (wr && bus.addr == 2'd2) pc_lat <= bus.din;
         if (bsr_lat) pc_lat[bsr_bit] <= bus.din[0];
         if (wr_bsr && bsr_inte_a) inte_a <= bus.din[0];
         if (wr_bsr && bsr_inte_b) inte_b <= bus.din[0];

         // A strobe fall beats a simultaneous CPU read: fresh data stays flagged
         if (a_in_m1) begin
            if (rd_a) begin
               ibf_a  <= 1'b0;
               intr_a <= 1'b0;
            end
            if (stb_a_fall) begin
               ina_lat <= pa_s;
               ibf_a   <= 1'b1;
               intr_a  <= 1'b0;
            end else if (stb_a_rise && ibf_a && inte_a && !rd_a) begin
               intr_a <= 1'b1;
            end
         end
         if (a_out_m1) begin
            if (wr_a) begin
               obf_a_n <= 1'b0;
               intr_a  <= 1'b0;
            end else begin
               if (ack_a_fall) obf_a_n <= 1'b1;
               if (ack_a_rise && obf_a_n && inte_a) intr_a <= 1'b1;
            end
         end

         if (b_m1 && b_in) begin
            if (rd_b) begin
               ibf_b  <= 1'b0;
               intr_b <= 1'b0;
            end
            if (hs_b_fall) begin
               inb_lat <= pb_s;
               ibf_b   <= 1'b1;
               intr_b  <= 1'b0;
            end else if (hs_b_rise && ibf_b && inte_b && !rd_b) begin
               intr_b <= 1'b1;
            end
         end
         if (b_m1 && !b_in) begin
            if (wr_b) begin
               obf_b_n <= 1'b0;
               intr_b  <= 1'b0;
            end else begin
               if (hs_b_fall) obf_b_n <= 1'b1;
               if (hs_b_rise && obf_b_n && inte_b) intr_b <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pia8255_io.sv
// tb/tb_pia8255_io.sv - directed bench for pia8255_io: mode 0, BSR, mode 1 in/out, async reset
module tb_pia8255_io;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'h50;
   logic [7:0] pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;
   logic       irq;
   logic [7:0] rdata;
   int         n_checks = 0;
   int         n_fail   = 0;

   pia8255_io_if bus ();

   pia8255_io dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .pa_in   (pa_in),
      .pb_in   (pb_in),
      .pc_in   (pc_in),
      .pa_out  (pa_out),
      .pb_out  (pb_out),
      .pc_out  (pc_out),
      .pa_oe   (pa_oe),
      .pb_oe   (pb_oe),
      .pc_oe   (pc_oe),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.enable = 1'b1;
      bus.rnw    = 1'b0;
      bus.addr   = a;
      bus.din    = d;
      @(negedge clk);
      bus.enable = 1'b0;
      bus.rnw    = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.enable = 1'b1;
      bus.rnw    = 1'b1;
      bus.addr   = a;
      #1 d = bus.dout;
      @(negedge clk);
      bus.enable = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.rnw    = 1'b1;
      bus.addr   = 2'd0;
      bus.din    = 8'h00;
      wait_cyc(3);

      // T1: reset state and input synchroniser latency
      check("t1_pa_oe", pa_oe, 8'h00);
      check("t1_pb_oe", pb_oe, 8'h00);
      check("t1_pc_oe", pc_oe, 8'h00);
      check("t1_pa_out", pa_out, 8'h00);
      check("t1_pc_out", pc_out, 8'h00);
      check("t1_irq", {7'd0, irq}, 8'h00);
      reset_n = 1'b1;
      wait_cyc(3);
      pa_in = 8'h5A;
      wait_cyc(1);
      check("t1_sync_early", bus.dout, 8'h00);
      wait_cyc(1);
      check("t1_sync_done", bus.dout, 8'h5A);
      bus_rd(2'd0, rdata);
      check("t1_rd_pa", rdata, 8'h5A);

      // T2: mode 0 with PA out, PB in, PC split
      bus_wr(2'd3, 8'h8A);
      bus_wr(2'd0, 8'h3C);
      bus_wr(2'd2, 8'h0F);
      check("t2_pa_oe", pa_oe, 8'hFF);
      check("t2_pb_oe", pb_oe, 8'h00);
      check("t2_pc_oe", pc_oe, 8'h0F);
      check("t2_pa_out", pa_out, 8'h3C);
      check("t2_pc_out", pc_out, 8'h0F);
      pb_in = 8'hC3;
      wait_cyc(2);
      bus_rd(2'd1, rdata);
      check("t2_rd_pb", rdata, 8'hC3);
      bus_rd(2'd2, rdata);
      check("t2_rd_pc", rdata, 8'h5F);
      bus_rd(2'd0, rdata);
      check("t2_rd_pa", rdata, 8'h3C);
      bus_rd(2'd3, rdata);
      check("t2_rd_ctrl", rdata, 8'h00);

      // T3: bit set/reset on PC
      bus_wr(2'd3, 8'h05);
      check("t3_bsr05", pc_out, 8'h0F);
      bus_wr(2'd3, 8'h04);
      check("t3_bsr04", pc_out, 8'h0B);
      bus_wr(2'd3, 8'h0F);
      check("t3_bsr0f", pc_out, 8'h8B);

      // T4: port A mode 1 strobed input
      bus_wr(2'd3, 8'hB0);
      check("t4_pc_oe", pc_oe, 8'hEF);
      check("t4_pa_oe", pa_oe, 8'h00);
      check("t4_pc_out", pc_out, 8'h00);
      bus_wr(2'd3, 8'h09);
      check("t4_inte_bsr", pc_out, 8'h00);
      pa_in = 8'h77;
      wait_cyc(3);
      pc_in = 8'h40;
      wait_cyc(2);
      check("t4_ibf_early", pc_out, 8'h00);
      wait_cyc(1);
      check("t4_ibf", pc_out, 8'h20);
      check("t4_irq_lo", {7'd0, irq}, 8'h00);
      pa_in = 8'h11;
      pc_in = 8'h50;
      wait_cyc(3);
      check("t4_intr", pc_out, 8'h28);
      check("t4_irq_hi", {7'd0, irq}, 8'h01);
      bus_rd(2'd0, rdata);
      check("t4_rd_pa", rdata, 8'h77);
      check("t4_ibf_clr", pc_out, 8'h00);
      check("t4_irq_clr", {7'd0, irq}, 8'h00);

      // T5: port A mode 1 strobed output
      bus_wr(2'd3, 8'hA0);
      check("t5_pc_oe", pc_oe, 8'hBF);
      check("t5_pa_oe", pa_oe, 8'hFF);
      check("t5_pc_out", pc_out, 8'h80);
      bus_wr(2'd3, 8'h0D);
      check("t5_inte_bsr", pc_out, 8'h80);
      bus_wr(2'd0, 8'h99);
      check("t5_pa_out", pa_out, 8'h99);
      check("t5_obf_lo", pc_out, 8'h00);
      @(negedge clk);
      pc_in = 8'h10;
      wait_cyc(3);
      check("t5_obf_hi", pc_out, 8'h80);
      check("t5_irq_lo", {7'd0, irq}, 8'h00);
      pc_in = 8'h50;
      wait_cyc(3);
      check("t5_intr", pc_out, 8'h88);
      check("t5_irq_hi", {7'd0, irq}, 8'h01);
      bus_wr(2'd0, 8'h42);
      check("t5_irq_clr", {7'd0, irq}, 8'h00);
      check("t5_obf_again", pc_out, 8'h00);
      check("t5_pa_out2", pa_out, 8'h42);

      // T6: asynchronous reset in the middle of a pending input handshake
      bus_wr(2'd3, 8'hB0);
      bus_wr(2'd3, 8'h09);
      pc_in = 8'h40;
      wait_cyc(3);
      pc_in = 8'h50;
      wait_cyc(3);
      check("t6_pre_irq", {7'd0, irq}, 8'h01);
      check("t6_pre_pc", pc_out, 8'h28);
      #2 reset_n = 1'b0;
      #1;
      check("t6_irq", {7'd0, irq}, 8'h00);
      check("t6_pc_out", pc_out, 8'h00);
      check("t6_pa_oe", pa_oe, 8'h00);
      check("t6_pb_oe", pb_oe, 8'h00);
      check("t6_pc_oe", pc_oe, 8'h00);
      wait_cyc(2);
      reset_n = 1'b1;
      wait_cyc(3);
      bus_rd(2'd0, rdata);
      check("t6_rd_pa", rdata, 8'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
